// File: rtl/btn_edge_ctrl.sv
// btn_edge_ctrl
//   Push-button controller for the Bridge button slot. Each raw button is
//   synchronised through two flops and debounced. Press (rise) and release
//   (fall) events are latched as sticky flags. Software sees levels, flags
//   and an interrupt mask through word-aligned registers. A registered level
//   interrupt is raised whenever an unmasked flag is set.
//
// Ports
//   clk          CPU clock from the Bridge
//   rst          synchronous, active-high reset
//   addr[31:0]   byte address; only addr[3:2] is decoded
//   we           single-cycle write strobe
//   wdata[31:0]  write data
//   button_input raw asynchronous buttons, 1 = pressed
//   rdata[31:0]  combinational read data
//   irq          registered level interrupt = |({fall,rise} & mask)
//
// Register map (addr[3:2])
//   00 LEVEL  {0, stable}                         read-only
//   01 FLAGS  {0, fall[8 +: N_BTN], 0, rise}      write-1-to-clear, set wins
//   10 MASK   same layout as FLAGS                read/write
//   11 reserved, reads 0
module btn_edge_ctrl #(
  parameter int N_BTN      = 5,
  parameter int DEB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  input  logic [N_BTN-1:0] button_input,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_nxt;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rise_nxt;
  logic [N_BTN-1:0] fall_nxt;
  logic [N_BTN-1:0] clr_rise;
  logic [N_BTN-1:0] clr_fall;
  logic [N_BTN-1:0] mask_rise;
  logic [N_BTN-1:0] mask_fall;
  logic [CW-1:0]    cnt     [N_BTN];
  logic [CW-1:0]    cnt_nxt [N_BTN];

  logic [1:0] reg_sel;
  logic       wr_flags;
  logic       wr_mask;
  logic       unused_bits;

  assign reg_sel  = addr[3:2];
  assign wr_flags = we && (reg_sel == 2'b01);
  assign wr_mask  = we && (reg_sel == 2'b10);

  // Address bits outside [3:2] are decoded by the Bridge.
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

  // Debounce: the counter runs only while the synchronised input disagrees
  // with the accepted level; any agreeing cycle restarts it at zero.
  always_comb begin
    stable_nxt = stable;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear is applied before the new edge is OR-ed in, so a set on the same
  // edge as a write-1-to-clear keeps the flag.
  always_comb begin
    clr_rise = wr_flags ? wdata[N_BTN-1:0]  : '0;
    clr_fall = wr_flags ? wdata[8 +: N_BTN] : '0;
    rise_nxt = (rise & ~clr_rise) | (stable_nxt & ~stable);
    fall_nxt = (fall & ~clr_fall) | (stable & ~stable_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      rise      <= '0;
      fall      <= '0;
      mask_rise <= '0;
      mask_fall <= '0;
      irq       <= 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1     <= button_input;
      s2     <= s1;
      stable <= stable_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (wr_mask) begin
        mask_rise <= wdata[N_BTN-1:0];
        mask_fall <= wdata[8 +: N_BTN];
      end
      // Uses the current flag/mask registers: one cycle behind any change.
      irq <= |((rise & mask_rise) | (fall & mask_fall));
    end
  end

  always_comb begin
    rdata = '0;
    if (!rst) begin
      case (reg_sel)
        2'b00: rdata[N_BTN-1:0] = stable;
        2'b01: begin
          rdata[N_BTN-1:0]  = rise;
          rdata[8 +: N_BTN] = fall;
        end
        2'b10: begin
          rdata[N_BTN-1:0]  = mask_rise;
          rdata[8 +: N_BTN] = mask_fall;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_edge_ctrl.sv
module tb_btn_edge_ctrl;

  localparam int N   = 5;
  localparam int DEB = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   addr;
  logic          we;
  logic [31:0]   wdata;
  logic [N-1:0]  button_input;
  logic [31:0]   rdata;
  logic          irq;

  int n_checks;
  int n_errors;

  btn_edge_ctrl #(.N_BTN(N), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .we           (we),
    .wdata        (wdata),
    .button_input (button_input),
    .rdata        (rdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a button's accepted level flips once the last DEB
  // synchronised samples all disagree with it.
  logic [N-1:0] m_stable, m_rise, m_fall, m_mrise, m_mfall;
  logic         m_irq;
  logic [N-1:0] m_pipe[$];
  logic [N-1:0] m_hist[$];

  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [N-1:0] b);
    logic [N-1:0] s2v;
    logic [N-1:0] new_st;
    logic         new_irq;
    logic         flip;
    if (r) begin
      m_stable = '0; m_rise = '0; m_fall = '0;
      m_mrise = '0; m_mfall = '0; m_irq = 1'b0;
      m_pipe.delete();
      m_pipe.push_back('0);
      m_pipe.push_back('0);
      m_hist.delete();
    end else begin
      s2v = m_pipe.pop_front();
      m_pipe.push_back(b);
      m_hist.push_back(s2v);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      new_st = m_stable;
      for (int k = 0; k < N; k++) begin
        flip = (m_hist.size() == DEB);
        foreach (m_hist[j]) if (m_hist[j][k] == m_stable[k]) flip = 1'b0;
        if (flip) new_st[k] = ~m_stable[k];
      end
      new_irq = |((m_rise & m_mrise) | (m_fall & m_mfall));
      if (w && a[3:2] == 2'b01) begin
        m_rise = m_rise & ~d[N-1:0];
        m_fall = m_fall & ~d[8 +: N];
      end
      m_rise = m_rise | (new_st & ~m_stable);
      m_fall = m_fall | (m_stable & ~new_st);
      if (w && a[3:2] == 2'b10) begin
        m_mrise = d[N-1:0];
        m_mfall = d[8 +: N];
      end
      m_stable = new_st;
      m_irq    = new_irq;
    end
  endtask

  function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (!r) begin
      case (a[3:2])
        2'b00: v[N-1:0] = m_stable;
        2'b01: begin v[N-1:0] = m_rise;  v[8 +: N] = m_fall;  end
        2'b10: begin v[N-1:0] = m_mrise; v[8 +: N] = m_mfall; end
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, step the model on the rising
  // edge, compare shortly after.
  task automatic drive_cycle(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [N-1:0] b);
    @(negedge clk);
    rst = r; we = w; addr = a; wdata = d; button_input = b;
    @(posedge clk);
    model_step(r, w, a, d, b);
    #1;
    check("model_rdata", rdata, m_rdata(r, a));
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  typedef struct {
    logic         r;
    logic         w;
    logic [31:0]  a;
    logic [31:0]  d;
    logic [N-1:0] b;
    logic [31:0]  exp_rd;
    logic         exp_irq;
    string        name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [N-1:0] b,
                              input logic [31:0] er, input logic ei, input string nm);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.b = b;
    v.exp_rd = er; v.exp_irq = ei; v.name = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] cur;
    logic [31:0]  ra;
    clk = 1'b0; rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; button_input = '0;
    n_checks = 0; n_errors = 0;

    // reset with all buttons held
    for (int i = 0; i < 3; i++) add(1, 0, 32'h0, 32'h0, 5'h1F, 32'h0, 0, "rst");
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 5'h1F, 32'h0, 0, "lvl_wait");
    add(0, 0, 32'h0, 32'h0, 5'h1F, 32'h1F, 0, "lvl_up");
    add(0, 0, 32'h4, 32'h0, 5'h1F, 32'h1F, 0, "flags_rise");
    add(0, 1, 32'h4, 32'h1F, 5'h1F, 32'h0, 0, "clr_rise");
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 5'h00, 32'h1F, 0, "rel_wait");
    add(0, 0, 32'h0, 32'h0, 5'h00, 32'h0, 0, "rel_done");
    add(0, 0, 32'h4, 32'h0, 5'h00, 32'h1F00, 0, "flags_fall");
    add(0, 1, 32'h4, 32'h1F00, 5'h00, 32'h0, 0, "clr_fall");
    // bouncing button 2
    for (int i = 0; i < 40; i++)
      add(0, 0, (i % 2 != 0) ? 32'h4 : 32'h0, 32'h0, ((i / 2) % 2 != 0) ? 5'h00 : 5'h04,
          32'h0, 0, "reject");
    for (int i = 0; i < 6; i++)
      add(0, 0, (i % 2 != 0) ? 32'h4 : 32'h0, 32'h0, 5'h00, 32'h0, 0, "reject_hold");
    // press / release latency
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 5'h01, 32'h0, 0, "press_wait");
    add(0, 0, 32'h0, 32'h0, 5'h01, 32'h01, 0, "press_lvl");
    add(0, 0, 32'h4, 32'h0, 5'h01, 32'h001, 0, "press_flag");
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 5'h00, 32'h01, 0, "release_wait");
    add(0, 0, 32'h0, 32'h0, 5'h00, 32'h0, 0, "release_lvl");
    add(0, 0, 32'h4, 32'h0, 5'h00, 32'h101, 0, "release_flag");
    // interrupt and write-1-to-clear
    add(0, 1, 32'h8, 32'h100, 5'h00, 32'h100, 0, "mask_wr");
    add(0, 0, 32'h4, 32'h0, 5'h00, 32'h101, 1, "irq_set");
    add(0, 1, 32'h4, 32'h001, 5'h00, 32'h100, 1, "w1c_rise");
    add(0, 1, 32'h4, 32'h100, 5'h00, 32'h0, 1, "w1c_fall");
    add(0, 0, 32'h4, 32'h0, 5'h00, 32'h0, 0, "irq_clr");
    // clear colliding with a new rise
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 5'h02, 32'h0, 0, "coll_wait");
    add(0, 1, 32'h4, 32'h002, 5'h02, 32'h002, 0, "collision");
    add(0, 0, 32'h0, 32'h0, 5'h02, 32'h02, 0, "coll_lvl");
    // ignored writes
    add(0, 1, 32'h0, 32'hFFFF_FFFF, 5'h02, 32'h02, 0, "lvl_wr");
    add(0, 1, 32'hC, 32'hFFFF_FFFF, 5'h02, 32'h0, 0, "rsv_wr");
    add(0, 0, 32'h8, 32'h0, 5'h02, 32'h100, 0, "mask_keep");
    add(0, 0, 32'h4, 32'h0, 5'h02, 32'h002, 0, "flags_keep");
    add(0, 0, 32'h0, 32'h0, 5'h02, 32'h02, 0, "lvl_keep");
    // mask unused bits and irq follow
    add(0, 1, 32'h8, 32'hFFFF_FFFF, 5'h02, 32'h1F1F, 0, "mask_ones");
    add(0, 0, 32'h8, 32'h0, 5'h02, 32'h1F1F, 1, "mask_irq");
    add(0, 1, 32'h8, 32'h0, 5'h02, 32'h0, 1, "mask_zero");
    add(0, 0, 32'h4, 32'h0, 5'h02, 32'h002, 0, "mask_irq_off");

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
      check(tbl[i].name, rdata, tbl[i].exp_rd);
      check({tbl[i].name, "_irq"}, {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end

    // reset in the middle of a debounce, button held through release
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 32'h0, 32'h0, 5'h0A);
      check("mid_deb_hold", rdata, 32'h02);
    end
    drive_cycle(1, 0, 32'h0, 32'h0, 5'h0A);
    check("mid_deb_rst", rdata, 32'h0);
    check("mid_deb_rst_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, 32'h0, 32'h0, 5'h0A);
      check("rst_hold_wait", rdata, 32'h0);
    end
    drive_cycle(0, 0, 32'h0, 32'h0, 5'h0A);
    check("rst_hold_lvl", rdata, 32'h0A);
    drive_cycle(0, 0, 32'h4, 32'h0, 5'h0A);
    check("rst_hold_flag", rdata, 32'h00A);

    // randomized traffic against the model
    cur = 5'h0A;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
      ra = $urandom();
      drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, ra,
                  $urandom(), cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_edge_ctrl.md
Name: btn_edge_ctrl

Overview:
Memory-mapped push-button controller between the 5 board buttons and the CPU bus Bridge, sitting in the Bridge's button peripheral slot.
- Synchronises and debounces each button.
- Latches press and release events as sticky flags.
- Exposes levels, flags and an interrupt mask to software through word-aligned registers.
- Drives a level interrupt request for a future interrupt controller.

Parameters:
N_BTN, 5, number of button inputs (1..8).
DEB_CYCLES, 250000, consecutive clk cycles a changed input must persist before being accepted (10 ms at 25 MHz); minimum 2.

Ports:
clk  input  1  CPU clock from Bridge (clk_to_btn).
rst  input  1  synchronous, active-high reset.
addr  input  32  bus byte address; only addr[3:2] decoded, Bridge performs base decode.
we  input  1  write strobe, single cycle, valid with addr/wdata.
wdata  input  32  write data.
button_input  input  N_BTN  raw asynchronous buttons, active-high (1 = pressed).
rdata  output  32  read data, combinational from addr and registers.
irq  output  1  level interrupt = |(flags & mask), registered.

Behaviour:
- Reset (rst=1 at a clk edge) clears every register: sync stages, stable levels, debounce counters, rise/fall flags, mask, irq. While reset is applied, rdata returns 0 for every offset. Reset mid-debounce discards the partial count.
- Synchroniser: two flops per bit, s1 <= button_input, s2 <= s1.
- Debounce, per bit, one counter of width clog2(DEB_CYCLES):
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pin change held steady is visible in stable exactly 2+DEB_CYCLES edges after the first edge that samples it.
  - A glitch shorter than DEB_CYCLES cycles (at s2) never changes stable. Each bounce back to the stable value restarts the count at 0.
- Edge detect, same edge stable updates:
  - rise[i] set when stable[i] goes 0->1.
  - fall[i] set when stable[i] goes 1->0.
  - Flags are sticky until software clears them.
- A button held through reset release produces a rise flag 2+DEB_CYCLES cycles after reset deasserts. This is required behaviour.
- Register map (addr[3:2]):
  - 00 LEVEL: read {0, stable[N_BTN-1:0]}. Writes ignored.
  - 01 FLAGS: read {0, fall at bits [8+N_BTN-1:8], 0, rise at bits [N_BTN-1:0]}. Write is write-1-to-clear, same bit layout. If a write-1 clear and a new set occur in the same cycle, the set wins (flag stays 1).
  - 10 MASK: read/write, same layout as FLAGS. Unused bits read 0 and ignore writes.
  - 11 reserved: reads 0, writes ignored.
- Writes take effect at the clk edge where we=1. A read in the following cycle returns the updated value. Reads have no side effects.
- irq <= |({fall,rise} & mask) at each edge, so there is 1 cycle latency from a flag or mask change to irq.
- Upper rdata bits outside the defined fields are always 0.

Test Plan:
All cases use DEB_CYCLES=4, N_BTN=5.
- Reset: apply rst for 3 cycles with button_input=5'h1F -> after release, LEVEL reads 0 for the first 5 cycles. LEVEL reads 0x1F at cycle 6 and FLAGS reads 0x0000001F. irq stays 0 while mask=0.
- Debounce reject: button 2 toggles 1/0 every 2 cycles for 40 cycles, then held 0 -> LEVEL stays 0x00 and FLAGS stays 0 throughout.
- Press/release latency: button 0 rises and holds -> LEVEL bit0 = 1 exactly 6 edges later and FLAGS = 0x001. Release -> 6 edges later LEVEL = 0 and FLAGS = 0x101.
- W1C and collision:
  - Write 0x001 to FLAGS -> reads 0x100.
  - Write 0x002 on the same edge button 1's stable rises -> FLAGS bit1 reads 1.
- Interrupt: write MASK=0x100 while FLAGS=0x101 -> irq=1 one cycle later. Write 0x100 to FLAGS -> irq=0 one cycle after the write.
- Reserved/LEVEL writes: write 0xFFFFFFFF to offsets 0x00 and 0x0C -> LEVEL, FLAGS and MASK unchanged, offset 0x0C reads 0.
